// File: rtl/board_scan_ctrl.sv
// One move-generation pass: clear squares, settle rays, then scan 64x16 move slots and stream non-empty words.
// All outputs registered; 2 cycles per slot plus EMIT cycles; move_valid holds until move_ready.
module board_scan_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int MOVE_W        = 24,
  parameter int CNT_W         = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              engine_color,
  output logic              busy,
  output logic              done,
  output logic              board_clear,
  output logic              board_enable,
  output logic              board_color,
  output logic [5:0]        scan_sq,
  output logic [3:0]        scan_dir,
  input  logic [MOVE_W-1:0] scan_data,
  output logic              move_valid,
  input  logic              move_ready,
  output logic [MOVE_W-1:0] move_data,
  output logic [CNT_W-1:0]  move_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_FETCH,
    S_CHECK,
    S_EMIT,
    S_DONE
  } state_t;

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic [SET_W-1:0]  settle_cnt;
  logic [9:0]        slot;
  logic              slot_last;
  logic              data_hit;
  logic              launch;
  logic              handshake;
  logic              advance;
  logic              busy_d;
  logic              done_d;
  logic              clear_d;
  logic              enable_d;
  logic              valid_d;

  // slot is {square, direction}: direction is the inner loop
  assign {scan_sq, scan_dir} = slot;
  assign slot_last = &slot;
  assign data_hit  = |scan_data;
  assign launch    = (state == S_IDLE) && start;
  assign handshake = (state == S_EMIT) && move_ready && !abort;
  assign advance   = ((state == S_CHECK) && !data_hit && !abort) || handshake;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:   if (start) next_state = S_CLEAR;
      S_CLEAR:  next_state = S_SETTLE;
      S_SETTLE: if (settle_cnt == SET_LAST) next_state = S_FETCH;
      S_FETCH:  next_state = S_CHECK;
      S_CHECK: begin
        if (data_hit)       next_state = S_EMIT;
        else if (slot_last) next_state = S_DONE;
        else                next_state = S_FETCH;
      end
      S_EMIT: begin
        if (move_ready) next_state = slot_last ? S_DONE : S_FETCH;
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) next_state = S_IDLE;
  end

  // Outputs are decoded from the next state so they line up with the state they describe
  always_comb begin
    busy_d   = (next_state != S_IDLE) && (next_state != S_DONE);
    done_d   = (next_state == S_DONE);
    clear_d  = (next_state == S_CLEAR);
    enable_d = (next_state == S_SETTLE) || (next_state == S_FETCH) ||
               (next_state == S_CHECK)  || (next_state == S_EMIT);
    valid_d  = (next_state == S_EMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      board_clear  <= 1'b0;
      board_enable <= 1'b0;
      move_valid   <= 1'b0;
    end else begin
      busy         <= busy_d;
      done         <= done_d;
      board_clear  <= clear_d;
      board_enable <= enable_d;
      move_valid   <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      board_color <= 1'b0;
      settle_cnt  <= '0;
      slot        <= '0;
      move_data   <= '0;
      move_count  <= '0;
    end else begin
      if (launch) begin
        board_color <= engine_color;
        settle_cnt  <= '0;
        slot        <= '0;
        move_count  <= '0;
      end else begin
        if (state == S_SETTLE) settle_cnt <= settle_cnt + SET_W'(1);
        if (advance) slot <= slot + 10'd1;
        if (handshake && (move_count != {CNT_W{1'b1}})) begin
          move_count <= move_count + CNT_W'(1);
        end
      end
      if ((state == S_CHECK) && data_hit && !abort) move_data <= scan_data;
    end
  end

endmodule

// File: tb/tb_board_scan_ctrl.sv
// Bench for board_scan_ctrl: slot-timeline reference model checked every cycle, plus directed literal checks.
module tb_board_scan_ctrl;
  localparam int S  = 8;
  localparam int MW = 24;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, engine_color, move_ready;
  logic          busy, done, board_clear, board_enable, board_color, move_valid;
  logic [5:0]    scan_sq;
  logic [3:0]    scan_dir;
  logic [MW-1:0] scan_data, move_data;
  logic [CW-1:0] move_count;
  logic [MW-1:0] board [1024];

  int total = 0;
  int bad   = 0;

  board_scan_ctrl #(.SETTLE_CYCLES(S), .MOVE_W(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .engine_color(engine_color),
    .busy(busy), .done(done), .board_clear(board_clear), .board_enable(board_enable),
    .board_color(board_color), .scan_sq(scan_sq), .scan_dir(scan_dir), .scan_data(scan_data),
    .move_valid(move_valid), .move_ready(move_ready), .move_data(move_data), .move_count(move_count)
  );

  always #5 clk = ~clk;

  // square array read mux: one cycle of latency
  always @(posedge clk) scan_data <= board[{scan_sq, scan_dir}];

  int   ready_mode = 0;
  logic ready_hold = 1'b0;
  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       move_ready = 1'b1;
      1:       move_ready = ($urandom % 3) != 0;
      default: move_ready = ready_hold;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pass is a timeline; slot j's FETCH is at scan time 2j plus all EMIT cycles so far
  bit            m_ok = 1'b0, m_active = 1'b0, m_emit = 1'b0, m_color = 1'b0, is_done;
  int            m_t, m_k, m_extra, m_cnt = 0, s;
  int            slot_q[$];
  logic [MW-1:0] word_q[$];
  logic [33:0]   xfer_q[$];
  int            p_clr, p_clr_rel, p_en, p_done, p_done_rel, p_vld;

  task automatic begin_pass();
    m_active = 1'b1; m_t = 1; m_emit = 1'b0; m_k = 0; m_extra = 0; m_cnt = 0;
    m_color = engine_color;
    slot_q.delete(); word_q.delete(); xfer_q.delete();
    for (int i = 0; i < 1024; i++) begin
      if (board[i] != '0) begin
        slot_q.push_back(i);
        word_q.push_back(board[i]);
      end
    end
    p_clr = 0; p_clr_rel = 0; p_en = 0; p_done = 0; p_done_rel = 0; p_vld = 0;
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      s = m_t - (S + 2);
      is_done = 1'b0;
      if (m_active) begin
        if (!m_emit && (m_k < slot_q.size()) && (s == 2 * slot_q[m_k] + 2 + m_extra)) m_emit = 1'b1;
        is_done = !m_emit && (s == 2048 + m_extra);
      end
      check("busy", 64'(busy), 64'(m_active && !is_done));
      check("done", 64'(done), 64'(is_done));
      check("board_clear", 64'(board_clear), 64'(m_active && m_t == 1));
      check("board_enable", 64'(board_enable), 64'(m_active && m_t >= 2 && !is_done));
      check("board_color", 64'(board_color), 64'(m_color));
      check("move_valid", 64'(move_valid), 64'(m_emit));
      check("move_count", 64'(move_count), 64'(m_cnt));
      if (m_emit) begin
        check("move_data", 64'(move_data), 64'(word_q[m_k]));
        check("emit_slot", 64'({scan_sq, scan_dir}), 64'(slot_q[m_k]));
      end
      if (board_clear === 1'b1) begin p_clr++; p_clr_rel = m_t; end
      if (board_enable === 1'b1) p_en++;
      if (done === 1'b1) begin p_done++; p_done_rel = m_t; end
      if (move_valid === 1'b1) p_vld++;
      if (move_valid === 1'b1 && move_ready === 1'b1) xfer_q.push_back({scan_sq, scan_dir, move_data});
    end
    if (!rst_n) begin
      m_ok = 1'b1; m_active = 1'b0; m_emit = 1'b0; m_cnt = 0; m_color = 1'b0;
    end else if (m_ok) begin
      if (m_active && abort) begin
        m_active = 1'b0; m_emit = 1'b0;
      end else if (!m_active && start) begin
        begin_pass();
      end else if (m_active) begin
        if (m_emit) begin
          m_extra++;
          if (move_ready) begin
            m_emit = 1'b0; m_k++;
            if (m_cnt < 2047) m_cnt++;
          end
        end
        if (is_done) m_active = 1'b0;
        else m_t++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit color);
    start = 1'b1; engine_color = color;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int c = 0;
    @(negedge clk);
    while (done !== 1'b1 && c < bound) begin @(negedge clk); c++; end
    check("done_seen", 64'(done === 1'b1), 64'd1);
    tick();
  endtask

  task automatic wait_valid(input int bound);
    int c = 0;
    @(negedge clk);
    while (move_valid !== 1'b1 && c < bound) begin @(negedge clk); c++; end
    check("valid_seen", 64'(move_valid === 1'b1), 64'd1);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 1024; i++) board[i] = '0;
  endtask

  logic [MW-1:0] w1, w2, w3;
  logic [33:0]   e0;
  int            nmoves;

  initial begin
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; engine_color = 1'b1;
    clear_board();
    tick(2);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_clear", 64'(board_clear), 64'd0);
    check("rst_enable", 64'(board_enable), 64'd0);
    check("rst_color", 64'(board_color), 64'd0);
    check("rst_valid", 64'(move_valid), 64'd0);
    check("rst_idx", 64'({scan_sq, scan_dir}), 64'd0);
    check("rst_data", 64'(move_data), 64'd0);
    check("rst_count", 64'(move_count), 64'd0);
    rst_n = 1'b1; start = 1'b0;
    tick(2);

    // empty board
    do_start(1'b0);
    wait_done(3000);
    check("empty_done_cycle", 64'(p_done_rel), 64'd2058);
    check("empty_clear_cycles", 64'(p_clr), 64'd1);
    check("empty_clear_at", 64'(p_clr_rel), 64'd1);
    check("empty_enable_cycles", 64'(p_en), 64'd2056);
    check("empty_valid_cycles", 64'(p_vld), 64'd0);
    check("empty_count", 64'(move_count), 64'd0);

    // bishop DL at sq 28 and knight UUR at sq 43
    w1 = 24'($urandom_range(1, 24'hFFFFFF));
    w2 = 24'($urandom_range(1, 24'hFFFFFF));
    board[28*16+6] = w1;
    board[43*16+9] = w2;
    do_start(1'b1);
    wait_done(3000);
    check("two_done_cycle", 64'(p_done_rel), 64'd2060);
    check("two_count", 64'(move_count), 64'd2);
    check("two_xfers", 64'(xfer_q.size()), 64'd2);
    e0 = {6'd28, 4'd6, w1};
    check("two_first", 64'(xfer_q[0]), 64'(e0));
    e0 = {6'd43, 4'd9, w2};
    check("two_second", 64'(xfer_q[1]), 64'(e0));

    // backpressure on the last slot
    clear_board();
    w3 = 24'($urandom_range(1, 24'hFFFFFF));
    board[1023] = w3;
    ready_mode = 2; ready_hold = 1'b0;
    do_start(1'b0);
    wait_valid(3000);
    repeat (4) @(negedge clk);
    ready_hold = 1'b1;
    wait_done(20);
    check("bp_valid_cycles", 64'(p_vld), 64'd6);
    check("bp_done_cycle", 64'(p_done_rel), 64'd2064);
    check("bp_count", 64'(move_count), 64'd1);
    check("bp_xfers", 64'(xfer_q.size()), 64'd1);
    ready_mode = 0; ready_hold = 1'b0;

    // color latched at start; second start and color toggles ignored
    do_start(1'b1);
    tick(3);
    start = 1'b1; engine_color = 1'b0;
    tick();
    start = 1'b0;
    tick(100);
    engine_color = 1'b1;
    tick();
    engine_color = 1'b0;
    wait_done(3000);
    tick(5);
    check("color_held", 64'(board_color), 64'd1);
    check("color_one_done", 64'(p_done), 64'd1);
    check("color_idle", 64'(busy), 64'd0);

    // abort in EMIT after one accepted move
    clear_board();
    board[3]  = 24'($urandom_range(1, 24'hFFFFFF));
    board[10] = 24'($urandom_range(1, 24'hFFFFFF));
    ready_mode = 2; ready_hold = 1'b0;
    do_start(1'b0);
    wait_valid(100);
    ready_hold = 1'b1;
    @(negedge clk);
    ready_hold = 1'b0;
    wait_valid(100);
    @(posedge clk); #1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_valid", 64'(move_valid), 64'd0);
    check("abort_enable", 64'(board_enable), 64'd0);
    check("abort_count", 64'(move_count), 64'd1);
    tick(5);
    check("abort_no_done", 64'(p_done), 64'd0);
    ready_mode = 0;
    do_start(1'b0);
    wait_done(3000);
    check("after_abort_count", 64'(move_count), 64'd2);
    check("after_abort_done", 64'(p_done_rel), 64'd2060);

    // reset during the first CHECK
    clear_board();
    board[5] = 24'($urandom_range(1, 24'hFFFFFF));
    do_start(1'b1);
    tick(10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_enable", 64'(board_enable), 64'd0);
    check("rst_mid_valid", 64'(move_valid), 64'd0);
    check("rst_mid_color", 64'(board_color), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    tick(2);
    do_start(1'b1);
    wait_done(3000);
    check("after_rst_count", 64'(move_count), 64'd1);
    check("after_rst_done", 64'(p_done_rel), 64'd2059);

    // random boards with random backpressure
    ready_mode = 1;
    for (int p = 0; p < 4; p++) begin
      clear_board();
      nmoves = $urandom_range(0, 40);
      for (int m = 0; m < nmoves; m++) board[$urandom_range(0, 1023)] = 24'($urandom_range(1, 24'hFFFFFF));
      nmoves = 0;
      for (int i = 0; i < 1024; i++) if (board[i] != '0) nmoves++;
      do_start(1'($urandom % 2));
      wait_done(6000);
      check("rand_count", 64'(move_count), 64'(nmoves));
      check("rand_xfers", 64'(xfer_q.size()), 64'(nmoves));
      tick($urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
